// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped data cache: default geometry,
// address field positions and the controller state encoding.
package dcache_pkg;

    localparam int DC_SETS   = 32;
    localparam int DC_LINE_W = 256;
    localparam int DC_ADDR_W = 32;
    localparam int DC_WORD_W = 32;

    // Default address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2]
    localparam int DC_OFFSET_W  = 5;
    localparam int DC_INDEX_W   = 5;
    localparam int DC_TAG_W     = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;
    localparam int DC_WSEL_W    = 3;
    localparam int DC_WORD_LSB  = 2;
    localparam int DC_INDEX_LSB = DC_OFFSET_W;
    localparam int DC_TAG_LSB   = DC_OFFSET_W + DC_INDEX_W;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MISS      = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_REFILL    = 3'd3,
        ST_REFILL_OK = 3'd4
    } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read of one line, synchronous
// write of either a full refill line or a single store word.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int SETS   = DC_SETS,
    parameter int LINE_W = DC_LINE_W,
    parameter int TAG_W  = DC_TAG_W,
    parameter int IDX_W  = $clog2(SETS),
    parameter int WSEL_W = $clog2(LINE_W / DC_WORD_W)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [LINE_W-1:0]    rd_line_o,
    input  logic                 line_we_i,
    input  logic [TAG_W-1:0]     wr_tag_i,
    input  logic [LINE_W-1:0]    wr_line_i,
    input  logic                 word_we_i,
    input  logic [WSEL_W-1:0]    wr_wsel_i,
    input  logic [DC_WORD_W-1:0] wr_word_i
);

    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    assign rd_valid_o = r_valid[idx_i];
    assign rd_dirty_o = r_dirty[idx_i];
    assign rd_tag_o   = r_tag[idx_i];
    assign rd_line_o  = r_data[idx_i];

    // Only the status bits are reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (line_we_i) begin
            r_valid[idx_i] <= 1'b1;
            r_dirty[idx_i] <= 1'b0;
        end else if (word_we_i) begin
            r_dirty[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (line_we_i) begin
            r_tag[idx_i]  <= wr_tag_i;
            r_data[idx_i] <= wr_line_i;
        end else if (word_we_i) begin
            r_data[idx_i][{wr_wsel_i, 5'b00000} +: DC_WORD_W] <= wr_word_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller for the MEM stage.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int SETS   = DC_SETS,
    parameter int LINE_W = DC_LINE_W,
    parameter int ADDR_W = DC_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output state_t            dbg_state_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int WSEL_W = $clog2(LINE_W / DC_WORD_W);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    state_t r_state;
    state_t w_state_nxt;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [WSEL_W-1:0] w_wsel;
    logic [1:0]        w_unused_lsb;
    logic              w_req;
    logic              w_hit;
    logic              w_idle_hit;
    logic              w_start_miss;
    logic              w_word_we;
    logic              w_line_we;
    logic              w_rd_valid;
    logic              w_rd_dirty;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [LINE_W-1:0] w_rd_line;

    assign w_tag        = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx        = p1_addr_i[OFF_W +: IDX_W];
    assign w_wsel       = p1_addr_i[2 +: WSEL_W];
    assign w_unused_lsb = p1_addr_i[1:0];

    assign w_req        = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit        = w_req & w_rd_valid & (w_rd_tag == w_tag);
    assign w_idle_hit   = w_hit & (r_state == ST_IDLE);
    assign w_start_miss = w_req & ~w_hit & (r_state == ST_IDLE);
    // Both strobes high is a store; the store rides the normal hit path after a refill.
    assign w_word_we    = w_idle_hit & p1_MemWrite_i;

    assign p1_stall_o  = w_req & ~w_idle_hit;
    assign p1_data_o   = (p1_MemRead_i && w_hit) ? w_rd_line[{w_wsel, 5'b00000} +: 32] : 32'd0;
    assign dbg_state_o = r_state;

    dcache_sram #(
        .SETS   (SETS),
        .LINE_W (LINE_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .WSEL_W (WSEL_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (w_idx),
        .rd_valid_o (w_rd_valid),
        .rd_dirty_o (w_rd_dirty),
        .rd_tag_o   (w_rd_tag),
        .rd_line_o  (w_rd_line),
        .line_we_i  (w_line_we),
        .wr_tag_i   (w_tag),
        .wr_line_i  (mem_data_i),
        .word_we_i  (w_word_we),
        .wr_wsel_i  (w_wsel),
        .wr_word_i  (p1_data_i)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Memory outputs decode from state only, so reset drops the request at once.
    always_comb begin
        w_state_nxt  = r_state;
        w_line_we    = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_miss) begin
                    w_state_nxt = ST_MISS;
                end
            end
            ST_MISS: begin
                w_state_nxt = (w_rd_valid && w_rd_dirty) ? ST_WRITEBACK : ST_REFILL;
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {w_rd_tag, w_idx, {OFF_W{1'b0}}};
                mem_data_o   = w_rd_line;
                if (mem_ack_i) begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_line_we   = 1'b1;
                    w_state_nxt = ST_REFILL_OK;
                end
            end
            ST_REFILL_OK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_idle_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_start_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: table of accesses with expected stall length and memory
// traffic, a reference word memory for load data, and a latency-driven memory model.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int LM       = 10;
    localparam int LW       = 6;
    localparam int MAX_WAIT = 200;
    localparam int NVEC     = 14;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          stall;
        logic        wb;
        logic [31:0] wb_addr;
        logic        rf;
        logic [31:0] rf_addr;
    } vec_t;

    typedef struct {
        logic [31:0]  addr;
        logic         write;
        logic [255:0] line;
    } mem_ev_t;

    logic         clk = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  p1_addr_i = '0;
    logic [31:0]  p1_data_i = '0;
    logic         p1_MemRead_i = 1'b0;
    logic         p1_MemWrite_i = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    state_t       dbg_state_o;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int total = 0;
    int bad = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic resp_on = 1'b1;
    logic ack_pulse = 1'b0;

    logic [31:0] exp_q[$];
    mem_ev_t     mem_log[$];
    logic [31:0] arch_mem[logic [31:0]];
    logic [31:0] bk_mem[logic [31:0]];
    vec_t        vecs[NVEC];

    dcache_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .dbg_state_o   (dbg_state_o)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
`endif
    );

    // clock/reset
    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return arch_mem.exists(wa) ? arch_mem[wa] : pat(wa);
    endfunction

    function automatic logic [255:0] arch_line(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = arch_rd({a[31:5], 5'b0} + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  wa;
        for (int w = 0; w < 8; w++) begin
            wa = {a[31:5], 5'b0} + 32'(w * 4);
            l[w*32 +: 32] = bk_mem.exists(wa) ? bk_mem[wa] : pat(wa);
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Memory model: ack on the L-th enabled cycle of a request; after an ack it
    // spends one turnaround cycle before counting a chained request.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!resp_on) begin
                mem_ack_i = ack_pulse;
                cnt = 0;
            end else if (!mem_enable_o || mem_ack_i) begin
                mem_ack_i = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                mem_data_i = bk_line(mem_addr_o);
                if (cnt == (mem_write_o ? LW : LM)) begin
                    mem_ack_i = 1'b1;
                    mem_log.push_back('{mem_addr_o, mem_write_o, mem_write_o ? mem_data_o : mem_data_i});
                    if (mem_write_o) begin
                        for (int w = 0; w < 8; w++) bk_mem[mem_addr_o + 32'(w * 4)] = mem_data_o[w*32 +: 32];
                    end
                end
            end
        end
    end

    task automatic do_vec(input vec_t v, input string tag);
        int      n;
        mem_ev_t ev;
        logic [31:0] exp_w;
        @(negedge clk);
        p1_addr_i     = v.addr;
        p1_data_i     = v.wdata;
        p1_MemRead_i  = v.rd;
        p1_MemWrite_i = v.wr;
        if (v.rd && !v.wr) exp_q.push_back(arch_rd(v.addr));
        #2;
        n = 0;
        while (p1_stall_o && n < MAX_WAIT) begin
            n++;
            @(negedge clk);
            #2;
        end
        if (n >= MAX_WAIT) chk({tag, "_stall_timeout"}, 1, 0);
        chk({tag, "_stall_cycles"}, n, v.stall);
        if (v.rd && !v.wr) begin
            exp_w = exp_q.pop_front();
            chk({tag, "_load_data"}, p1_data_o, exp_w);
        end
        chk({tag, "_mem_txn_count"}, mem_log.size(), 32'(v.wb) + 32'(v.rf));
        if (v.wb && mem_log.size() > 0) begin
            ev = mem_log.pop_front();
            chk({tag, "_wb_write"}, ev.write, 1);
            chk({tag, "_wb_addr"}, ev.addr, v.wb_addr);
            chk({tag, "_wb_line"}, ev.line, arch_line(v.wb_addr));
        end
        if (v.rf && mem_log.size() > 0) begin
            ev = mem_log.pop_front();
            chk({tag, "_rf_write"}, ev.write, 0);
            chk({tag, "_rf_addr"}, ev.addr, v.rf_addr);
        end
        mem_log.delete();
        if (v.wr) arch_mem[{v.addr[31:2], 2'b00}] = v.wdata;
        exp_hits++;
        if (n > 0) exp_miss++;
        @(posedge clk);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int n;
        //            addr          wdata         rd    wr    stall            wb    wb_addr   rf    rf_addr
        vecs[0]  = '{32'h0000_0040, 32'h0,        1'b1, 1'b0, 3 + LM,          1'b0, 32'h0,    1'b1, 32'h40};
        vecs[1]  = '{32'h0000_0044, 32'h0,        1'b1, 1'b0, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[2]  = '{32'h0000_0048, 32'hDEADBEEF, 1'b0, 1'b1, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[3]  = '{32'h0000_0048, 32'h0,        1'b1, 1'b0, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[4]  = '{32'h0000_0448, 32'h0,        1'b1, 1'b0, 4 + LW + LM,     1'b1, 32'h40,   1'b1, 32'h440};
        vecs[5]  = '{32'h0000_0080, 32'h12345678, 1'b1, 1'b1, 3 + LM,          1'b0, 32'h0,    1'b1, 32'h80};
        vecs[6]  = '{32'h0000_0080, 32'h0,        1'b1, 1'b0, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[7]  = '{32'h0000_0040, 32'h0,        1'b1, 1'b0, 3 + LM,          1'b0, 32'h0,    1'b1, 32'h40};
        vecs[8]  = '{32'h0000_0048, 32'h0,        1'b1, 1'b0, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[9]  = '{32'h0000_007C, 32'h0,        1'b0, 1'b1, 3 + LM,          1'b0, 32'h0,    1'b1, 32'h60};
        vecs[10] = '{32'h0000_087C, 32'h0,        1'b1, 1'b0, 4 + LW + LM,     1'b1, 32'h60,   1'b1, 32'h860};
        vecs[11] = '{32'h0000_007C, 32'h0,        1'b1, 1'b0, 3 + LM,          1'b0, 32'h0,    1'b1, 32'h60};
        vecs[12] = '{32'h0000_0088, 32'h0,        1'b1, 1'b0, 0,               1'b0, 32'h0,    1'b0, 32'h0};
        vecs[13] = '{32'h0000_0480, 32'h0,        1'b1, 1'b0, 4 + LW + LM,     1'b1, 32'h80,   1'b1, 32'h480};
        vecs[9].wdata = $urandom_range(32'hFFFF_FFFE, 1);

        // reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_state", dbg_state_o, ST_IDLE);
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        rst_i = 1'b1;
        @(negedge clk);
        #2;
        chk("idle_stall", p1_stall_o, 0);
        chk("idle_data", p1_data_o, 0);
        chk("idle_mem_enable", mem_enable_o, 0);

        for (int i = 0; i < NVEC; i++) do_vec(vecs[i], $sformatf("v%0d", i));

        // reset asserted in the middle of a refill
        @(negedge clk);
        p1_addr_i    = 32'h0000_0100;
        p1_MemRead_i = 1'b1;
        n = 0;
        while (dbg_state_o != ST_REFILL && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach_refill", dbg_state_o, ST_REFILL);
        repeat (3) @(negedge clk);
        #2;
        chk("mid_refill_enable", mem_enable_o, 1);
        chk("mid_refill_addr", mem_addr_o, 32'h100);
        rst_i   = 1'b0;
        resp_on = 1'b0;
        #1;
        chk("mid_rst_enable_drop", mem_enable_o, 0);
        chk("mid_rst_state", dbg_state_o, ST_IDLE);
        p1_MemRead_i = 1'b0;
        mem_log.delete();
        exp_hits = 0;
        exp_miss = 0;
        @(negedge clk);
        #2;
        rst_i     = 1'b1;
        ack_pulse = 1'b1;
        @(negedge clk);
        #2;
        ack_pulse = 1'b0;
        chk("late_ack_seen", mem_ack_i, 1);
        chk("late_ack_enable", mem_enable_o, 0);
        chk("late_ack_stall", p1_stall_o, 0);
        @(posedge clk);
        #1;
        chk("late_ack_state", dbg_state_o, ST_IDLE);
        chk("late_ack_enable_after", mem_enable_o, 0);
        @(negedge clk);
        #2;
        resp_on = 1'b1;
        chk("late_ack_log", mem_log.size(), 0);

        do_vec('{32'h0000_0100, 32'h0, 1'b1, 1'b0, 3 + LM, 1'b0, 32'h0, 1'b1, 32'h100}, "r0");
        do_vec('{32'h0000_0104, 32'h0, 1'b1, 1'b0, 0,      1'b0, 32'h0, 1'b0, 32'h0},   "r1");
        do_vec('{32'h0000_0048, 32'h0, 1'b1, 1'b0, 3 + LM, 1'b0, 32'h0, 1'b1, 32'h40},  "r2");

`ifdef DCACHE_STATS_EN
        @(negedge clk);
        chk("stats_hits", hit_cnt_o, exp_hits);
        chk("stats_miss", miss_cnt_o, exp_miss);
`endif

        chk("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller for the MEM stage. It sits directly downstream of the EX/MEM pipeline register and consumes its ALU address, store data and MemRead/MemWrite strobes. It returns load data toward MEM/WB and drives the `stall` that freezes the pipeline registers on a miss. On the other side it handles whole-line refills and write-backs with data memory over a request/acknowledge handshake.

## Interface
- `SETS`, default 32: number of cache lines; must be a power of two.
- `LINE_W`, default 256: line width in bits (32 bytes).
- `ADDR_W`, default 32: byte address width.
- `clk_i` input 1: clock. All state updates on posedge.
- `rst_i` input 1: asynchronous, active-low reset.
- `p1_addr_i` input 32: byte address (ALUOut from EX/MEM).
- `p1_data_i` input 32: store data (forwarded RT from EX/MEM).
- `p1_MemRead_i` input 1: load request.
- `p1_MemWrite_i` input 1: store request.
- `p1_data_o` output 32: load data.
- `p1_stall_o` output 1: pipeline stall, driven to the stall input of every pipeline register.
- `mem_data_i` input 256: refill line.
- `mem_ack_i` input 1: one-cycle completion pulse from memory.
- `mem_data_o` output 256: write-back line.
- `mem_addr_o` output 32: line-aligned memory address.
- `mem_enable_o` output 1: memory request.
- `mem_write_o` output 1: 1 = write-back, 0 = refill.

## Operation
- Address split: tag = `addr[31:10]` (22 bits), index = `addr[9:5]`, word = `addr[4:2]`. `addr[1:0]` is ignored (word access only).
- Per line the controller keeps: valid, dirty, tag, 256-bit data. Only valid and dirty are reset; tag and data are not.
- `req = p1_MemRead_i | p1_MemWrite_i`. If both strobes are high, the access is treated as a store.
- `hit = req & valid[index] & (tag[index] == addr tag)`.
- `p1_stall_o = req & ~(hit & state==IDLE)`. This is combinational.
- `p1_data_o` = selected word when `p1_MemRead_i & hit`, else 0. This is combinational.
- Store hit in IDLE: the word is written into the line and dirty is set at the next posedge.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_OK.
  - IDLE → MISS when `req & ~hit`.
  - MISS → WRITEBACK if the victim is valid and dirty, else → REFILL.
  - WRITEBACK: `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o = {victim tag, index, 5'b0}`, `mem_data_o` = victim line. Goes → REFILL on `mem_ack_i`.
  - REFILL: `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o = {req tag, index, 5'b0}`. On `mem_ack_i` the line is loaded from `mem_data_i`, tag is written, valid=1, dirty=0, and the state goes → REFILL_OK.
  - REFILL_OK → IDLE. The request then hits in IDLE; a store is performed by the normal hit path.
- `mem_enable_o` is held high continuously from entry to WRITEBACK/REFILL until the `mem_ack_i` cycle inclusive. `mem_ack_i` is ignored in IDLE, MISS and REFILL_OK.
- Upstream holds `p1_*` stable while stalled, because EX/MEM is frozen. The controller does not latch the request.

## Timing
- Hit: zero added cycles. Load data is valid in the request cycle; a store commits at the next posedge.
- Clean miss: stall for `3 + Lm` cycles, where Lm = cycles from `mem_enable_o` rise to `mem_ack_i`.
- Dirty miss: stall for `4 + Lw + Lm` cycles, where Lw is the write-back latency.
- Reset values: state=IDLE, all valid=0, all dirty=0, `mem_enable_o=0`, `mem_write_o=0`, `mem_addr_o=0`, `mem_data_o=0`. `p1_stall_o=0` and `p1_data_o=0` while no request is present.
- Reset mid-operation: an outstanding memory transaction is abandoned, `mem_enable_o` drops asynchronously, and a late `mem_ack_i` is ignored.
- Request deasserted mid-miss (only possible via reset or flush): the FSM still completes the line fill. This is legal because the refilled line is consistent.

## Configuration
- `DCACHE_STATS_EN`: when defined, the block adds two 32-bit saturating counters, `hit_cnt_o` and `miss_cnt_o`, exposed as outputs.
  - `hit_cnt_o` increments on every IDLE cycle with a hit.
  - `miss_cnt_o` increments on every IDLE→MISS transition.
  - Both counters clear on reset.
- Without the macro, the counters and their ports do not exist and behaviour is otherwise identical.

## Structure
- Shared package `dcache_pkg`: state encoding (IDLE=0, MISS=1, WRITEBACK=2, REFILL=3, REFILL_OK=4), tag/index/offset widths and bit positions, and `LINE_W`.
- Sub-module `dcache_sram`: tag + valid + dirty + data array, with one combinational read port and one synchronous write port (full-line or single-word write with dirty update).
- `dcache_ctrl` contains the FSM, hit logic, word select/merge and memory interface.

## Test plan
- After reset, load from 0x0000_0040 with Lm=10 → stall for 13 cycles; `mem_addr_o=0x40`, `mem_write_o=0`; returns word 0 of `mem_data_i`; an immediate reload of 0x44 hits with zero stall.
- Store 0xDEADBEEF to 0x48 after that refill → no stall, dirty set; a load of 0x48 on the next cycle returns 0xDEADBEEF.
- Load 0x0000_0448 (same index, different tag) → WRITEBACK to 0x40 with word 2 = 0xDEADBEEF, then REFILL at 0x440; stall for 4+Lw+Lm cycles.
- Both strobes high to 0x80 → treated as a store and the line is marked dirty.
- Assert `rst_i=0` during REFILL → `mem_enable_o` drops immediately; a later `mem_ack_i` is ignored; a subsequent load to the same address misses.
- With `DCACHE_STATS_EN`: 3 hits and 2 misses → `hit_cnt_o=3`, `miss_cnt_o=2`.
